// File: rtl/tmds_tx_gearbox.sv
// TMDS transmit gearbox: buffers NCH 10-bit words and emits 5-bit halves per rx0_pclkx2 cycle.
// Optional macro TMDS_PRBS_EN adds a prbs_en port and per-channel PRBS7 pattern on out_data.
module tmds_tx_gearbox #(
    parameter int unsigned NCH         = 3,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned START_LEVEL = 4,
    parameter logic [9:0]  IDLE_WORD   = 10'b1101010100
) (
    input  logic                      rx0_pclkx2,
    input  logic                      rx0_reset,
    input  logic                      enable,
    input  logic                      in_valid,
    input  logic [NCH*10-1:0]         in_data,
`ifdef TMDS_PRBS_EN
    input  logic                      prbs_en,
`endif
    output logic                      in_ready,
    output logic [NCH*5-1:0]          out_data,
    output logic [4:0]                clk_pattern,
    output logic                      phase,
    output logic [$clog2(DEPTH):0]    level,
    output logic [1:0]                state,
    output logic                      underflow,
    output logic                      overflow,
    input  logic                      clr_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned WW = NCH * 10;
    localparam int unsigned OW = NCH * 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            phase_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [WW-1:0]   mem_q [DEPTH];
    logic [WW-1:0]   hold_q, hold_d, sel_c;
    logic [OW-1:0]   out_q, out_d;
    logic [4:0]      clk_q, clk_d;
    logic            uf_q, uf_d, of_q, of_d;
    logic            push_c, pop_c, empty_c, start_c;

    assign empty_c  = (level_q == '0);
    assign start_c  = (level_q >= LW'(START_LEVEL));
    assign in_ready = enable && (level_q < LW'(DEPTH));
    assign push_c   = in_valid && in_ready;

    always_ff @(posedge rx0_pclkx2 or posedge rx0_reset) begin
        if (rx0_reset) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // FILL->RUN and RUN->FILL only happen on the pop edge; disable wins everywhere
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FILL;
                ST_FILL: if (phase_q && start_c) state_d = ST_RUN;
                ST_RUN:  if (phase_q && empty_c) state_d = ST_FILL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef TMDS_PRBS_EN
    logic [6:0]    prbs_q [NCH];
    logic [6:0]    prbs_d [NCH];
    logic [OW-1:0] prbs_bits_c;

    // x^7+x^6+1, five steps per cycle, oldest generated bit lands in the LSB
    always_comb begin
        logic [6:0] s;
        s           = '0;
        prbs_bits_c = '0;
        prbs_d      = prbs_q;
        for (int k = 0; k < NCH; k++) begin
            s = prbs_q[k];
            for (int b = 0; b < 5; b++) begin
                s = {s[5:0], s[6] ^ s[5]};
                prbs_bits_c[5*k+b] = s[0];
            end
            if (prbs_en) prbs_d[k] = s;
        end
    end

    always_ff @(posedge rx0_pclkx2 or posedge rx0_reset) begin
        if (rx0_reset) begin
            for (int k = 0; k < NCH; k++) prbs_q[k] <= 7'h7F;
        end else begin
            prbs_q <= prbs_d;
        end
    end
`endif

    // Output process: word selection on the pop edge, half-word muxing, sticky errors
    always_comb begin
        pop_c = 1'b0;
        sel_c = {NCH{IDLE_WORD}};
        uf_d  = uf_q & ~clr_err;
        of_d  = (of_q & ~clr_err) | (in_valid & enable & ~in_ready);
        out_d = '0;
        if (enable && phase_q) begin
            case (state_q)
                ST_FILL: pop_c = start_c;
                ST_RUN: begin
                    pop_c = !empty_c;
                    if (empty_c) uf_d = 1'b1;
                end
                default: pop_c = 1'b0;
            endcase
        end
        if (pop_c) sel_c = mem_q[rd_ptr_q];
        hold_d = phase_q ? sel_c : hold_q;
        clk_d  = phase_q ? 5'b11111 : 5'b00000;
        for (int k = 0; k < NCH; k++) begin
            out_d[5*k +: 5] = phase_q ? sel_c[10*k +: 5] : hold_q[10*k+5 +: 5];
        end
`ifdef TMDS_PRBS_EN
        if (prbs_en) out_d = prbs_bits_c;
`endif
    end

    // Disable flushes the FIFO; pointers wrap modulo DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (!enable) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_c, pop_c})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge rx0_pclkx2 or posedge rx0_reset) begin
        if (rx0_reset) begin
            phase_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= {NCH{IDLE_WORD}};
            out_q    <= {NCH{IDLE_WORD[4:0]}};
            clk_q    <= 5'b11111;
            uf_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            phase_q  <= ~phase_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
            out_q    <= out_d;
            clk_q    <= clk_d;
            uf_q     <= uf_d;
            of_q     <= of_d;
        end
    end

    always_ff @(posedge rx0_pclkx2) begin
        if (push_c) mem_q[wr_ptr_q] <= in_data;
    end

    assign out_data    = out_q;
    assign clk_pattern = clk_q;
    assign phase       = phase_q;
    assign level       = level_q;
    assign state       = state_q;
    assign underflow   = uf_q;
    assign overflow    = of_q;

endmodule

// File: tb/tb_tmds_tx_gearbox.sv
// Directed bench for tmds_tx_gearbox: per-edge vector table plus overflow, async-reset and PRBS sequences.
module tb_tmds_tx_gearbox;
    localparam int unsigned NCH = 3;

    typedef struct packed {
        logic       en, vld, clr;
        logic [9:0] d;
        logic [1:0] st;
        logic [3:0] lvl;
        logic [4:0] o0, o1, ck;
        logic       uf, of, rdy;
    } vec_t;

    vec_t vecs[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance: ch0 = d, ch1 = ~d, ch2 = d
    logic        en = 1'b0, vld = 1'b0, clr = 1'b0;
    logic [9:0]  d = '0;
    logic [29:0] in_data;
    logic        in_ready, phase, underflow, overflow;
    logic [14:0] out_data;
    logic [4:0]  clk_pattern;
    logic [3:0]  level;
    logic [1:0]  state;
    assign in_data = {d, ~d, d};

    // second instance with START_LEVEL = DEPTH so it can sit full in FILL
    logic        o_en = 1'b0, o_vld = 1'b0, o_clr = 1'b0;
    logic [9:0]  o_d = '0;
    logic        o_ready, o_phase, o_uf, o_of;
    logic [14:0] o_out;
    logic [4:0]  o_clk;
    logic [3:0]  o_level;
    logic [1:0]  o_state;

`ifdef TMDS_PRBS_EN
    logic prbs_en = 1'b0;
`endif

    tmds_tx_gearbox #(.NCH(NCH), .DEPTH(8), .START_LEVEL(4)) u_dut (
        .rx0_pclkx2 (clk),
        .rx0_reset  (rst),
        .enable     (en),
        .in_valid   (vld),
        .in_data    (in_data),
`ifdef TMDS_PRBS_EN
        .prbs_en    (prbs_en),
`endif
        .in_ready   (in_ready),
        .out_data   (out_data),
        .clk_pattern(clk_pattern),
        .phase      (phase),
        .level      (level),
        .state      (state),
        .underflow  (underflow),
        .overflow   (overflow),
        .clr_err    (clr)
    );

    tmds_tx_gearbox #(.NCH(NCH), .DEPTH(8), .START_LEVEL(8)) u_ovf (
        .rx0_pclkx2 (clk),
        .rx0_reset  (rst),
        .enable     (o_en),
        .in_valid   (o_vld),
        .in_data    ({o_d, o_d, o_d}),
`ifdef TMDS_PRBS_EN
        .prbs_en    (1'b0),
`endif
        .in_ready   (o_ready),
        .out_data   (o_out),
        .clk_pattern(o_clk),
        .phase      (o_phase),
        .level      (o_level),
        .state      (o_state),
        .underflow  (o_uf),
        .overflow   (o_of),
        .clr_err    (o_clr)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int e, input int v, input int c, input int dd,
                       input int st, input int lv, input int o0, input int o1,
                       input int ck, input int uf, input int of, input int rdy);
        vec_t x;
        x.en  = 1'(e);   x.vld = 1'(v);  x.clr = 1'(c);  x.d  = 10'(dd);
        x.st  = 2'(st);  x.lvl = 4'(lv); x.o0  = 5'(o0); x.o1 = 5'(o1);
        x.ck  = 5'(ck);  x.uf  = 1'(uf); x.of  = 1'(of); x.rdy = 1'(rdy);
        vecs.push_back(x);
    endtask

    function automatic logic [63:0] main_tuple();
        return 64'({phase, state, level, out_data, clk_pattern, underflow, overflow, in_ready});
    endfunction

    initial begin
        vec_t v;
        //   en vld clr data    st lvl  o0    o1    clk  uf of rdy
        add(0, 0, 0, 'h000,   0, 0, 'h1A, 'h1A, 'h00, 0, 0, 0);
        add(0, 1, 0, 'h155,   0, 0, 'h14, 'h14, 'h1F, 0, 0, 0);
        add(0, 0, 0, 'h000,   0, 0, 'h1A, 'h1A, 'h00, 0, 0, 0);
        add(0, 0, 0, 'h000,   0, 0, 'h14, 'h14, 'h1F, 0, 0, 0);
        add(1, 0, 0, 'h000,   1, 0, 'h1A, 'h1A, 'h00, 0, 0, 1);
        add(1, 1, 0, 'h155,   1, 1, 'h14, 'h14, 'h1F, 0, 0, 1);
        add(1, 0, 0, 'h000,   1, 1, 'h1A, 'h1A, 'h00, 0, 0, 1);
        add(1, 1, 0, 'h2AA,   1, 2, 'h14, 'h14, 'h1F, 0, 0, 1);
        add(1, 0, 0, 'h000,   1, 2, 'h1A, 'h1A, 'h00, 0, 0, 1);
        add(1, 1, 0, 'h0F0,   1, 3, 'h14, 'h14, 'h1F, 0, 0, 1);
        add(1, 0, 0, 'h000,   1, 3, 'h1A, 'h1A, 'h00, 0, 0, 1);
        add(1, 1, 0, 'h30F,   1, 4, 'h14, 'h14, 'h1F, 0, 0, 1);
        add(1, 0, 0, 'h000,   1, 4, 'h1A, 'h1A, 'h00, 0, 0, 1);
        add(1, 0, 0, 'h000,   2, 3, 'h15, 'h0A, 'h1F, 0, 0, 1);
        add(1, 0, 0, 'h000,   2, 3, 'h0A, 'h15, 'h00, 0, 0, 1);
        add(1, 0, 0, 'h000,   2, 2, 'h0A, 'h15, 'h1F, 0, 0, 1);
        add(1, 0, 0, 'h000,   2, 2, 'h15, 'h0A, 'h00, 0, 0, 1);
        add(1, 0, 0, 'h000,   2, 1, 'h10, 'h0F, 'h1F, 0, 0, 1);
        add(1, 0, 0, 'h000,   2, 1, 'h07, 'h18, 'h00, 0, 0, 1);
        add(1, 0, 0, 'h000,   2, 0, 'h0F, 'h10, 'h1F, 0, 0, 1);
        add(1, 1, 0, 'h1E1,   2, 1, 'h18, 'h07, 'h00, 0, 0, 1);
        add(1, 0, 0, 'h000,   2, 0, 'h01, 'h1E, 'h1F, 0, 0, 1);
        add(1, 0, 0, 'h000,   2, 0, 'h0F, 'h10, 'h00, 0, 0, 1);
        add(1, 1, 0, 'h0CD,   1, 1, 'h14, 'h14, 'h1F, 1, 0, 1);
        add(1, 0, 0, 'h000,   1, 1, 'h1A, 'h1A, 'h00, 1, 0, 1);
        add(1, 0, 1, 'h000,   1, 1, 'h14, 'h14, 'h1F, 0, 0, 1);
        add(1, 1, 0, 'h2E7,   1, 2, 'h1A, 'h1A, 'h00, 0, 0, 1);
        add(1, 1, 0, 'h111,   1, 3, 'h14, 'h14, 'h1F, 0, 0, 1);
        add(1, 1, 0, 'h222,   1, 4, 'h1A, 'h1A, 'h00, 0, 0, 1);
        add(1, 1, 0, 'h333,   2, 4, 'h0D, 'h12, 'h1F, 0, 0, 1);
        add(1, 1, 0, 'h044,   2, 5, 'h06, 'h19, 'h00, 0, 0, 1);
        add(1, 1, 0, 'h055,   2, 5, 'h07, 'h18, 'h1F, 0, 0, 1);
        add(0, 1, 0, 'h066,   0, 0, 'h17, 'h08, 'h00, 0, 0, 0);
        add(0, 0, 0, 'h000,   0, 0, 'h14, 'h14, 'h1F, 0, 0, 0);
        add(1, 0, 0, 'h000,   1, 0, 'h1A, 'h1A, 'h00, 0, 0, 1);
        add(1, 0, 0, 'h000,   1, 0, 'h14, 'h14, 'h1F, 0, 0, 1);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset", main_tuple(), 64'({1'b0, 2'd0, 4'd0, {3{5'h14}}, 5'h1F, 1'b0, 1'b0, 1'b0}));

        for (int i = 0; i < vecs.size(); i++) begin
            v   = vecs[i];
            en  = v.en;
            vld = v.vld;
            clr = v.clr;
            d   = v.d;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", i + 1), main_tuple(),
                64'({1'(i % 2 == 0), v.st, v.lvl, v.o0, v.o1, v.o0, v.ck, v.uf, v.of, v.rdy}));
        end
        vld = 1'b0;
        clr = 1'b0;

        // fill to DEPTH without pops, then one dropped word
        o_en  = 1'b1;
        o_vld = 1'b1;
        for (int k = 0; k < 9; k++) begin
            o_d = 10'(k + 1);
            @(posedge clk);
            @(negedge clk);
            if (k == 0) chk("ovf_enter_fill", 64'({o_state, o_level}), 64'({2'd1, 4'd1}));
            if (k == 7) chk("ovf_full", 64'({o_level, o_ready, o_of}), 64'({4'd8, 1'b0, 1'b0}));
            if (k == 8) chk("ovf_drop", 64'({o_state, o_level, o_ready, o_of}),
                            64'({2'd1, 4'd8, 1'b0, 1'b1}));
        end
        // clear coinciding with a new drop: flag stays set
        o_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ovf_clr_vs_new", 64'({o_state, o_level, o_of, o_ready}), 64'({2'd2, 4'd7, 1'b1, 1'b1}));
        o_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ovf_clr", 64'({o_of, o_uf, o_level}), 64'({1'b0, 1'b0, 4'd7}));
        o_clr = 1'b0;

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_main", main_tuple(),
            64'({1'b0, 2'd0, 4'd0, {3{5'h14}}, 5'h1F, 1'b0, 1'b0, 1'b1}));
        chk("async_rst_ovf", 64'({o_phase, o_state, o_level, o_out, o_clk, o_uf, o_of}),
            64'({1'b0, 2'd0, 4'd0, {3{5'h14}}, 5'h1F, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;

`ifdef TMDS_PRBS_EN
        begin
            bit         hist[$];
            logic [4:0] e;
            bit         nb;
            for (int k = 0; k < 7; k++) hist.push_back(1'b1);
            en      = 1'b0;
            prbs_en = 1'b1;
            for (int c = 0; c < 40; c++) begin
                for (int b = 0; b < 5; b++) begin
                    nb = hist[hist.size() - 7] ^ hist[hist.size() - 6];
                    hist.push_back(nb);
                    e[b] = nb;
                end
                @(posedge clk);
                @(negedge clk);
                chk($sformatf("prbs%0d", c), 64'(out_data[9:0]), 64'({e, e}));
            end
            prbs_en = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tmds_tx_gearbox.md
Name: tmds_tx_gearbox

Overview:
Parametrised TMDS transmit gearbox for the HDMI pass-through path, in the rx0_pclkx2 domain. Buffers NCH 10-bit TMDS words in a small FIFO and emits them as 5-bit halves per pclkx2 cycle to the 5:1 OSERDES instances. Generates the phase-aligned 5-bit TMDS clock-channel pattern and recovers from underflow by inserting a control idle word. Generalises the fixed 3-channel toggle/clock-pattern logic with configurable channel count, depth, start threshold and error reporting.

Parameters:
NCH, 3, number of TMDS data channels
DEPTH, 8, FIFO depth in words; power of 2, >= 4
START_LEVEL, 4, FIFO level required to leave FILL; 1..DEPTH
IDLE_WORD, 10'b1101010100, word sent while idle, filling or underflowed

Ports:
rx0_pclkx2  in  1  clock, 2x pixel clock
rx0_reset  in  1  reset, asynchronous, active-high
enable  in  1  0 = IDLE state, FIFO flushed
in_valid  in  1  word-valid strobe
in_data  in  NCH*10  channel k at bits [10k+9:10k]
in_ready  out  1  = enable && (level < DEPTH), combinational
out_data  out  NCH*5  registered 5-bit half per channel, LSB half first
clk_pattern  out  5  registered clock-channel pattern
phase  out  1  half select; 0 = low half on out_data
level  out  $clog2(DEPTH)+1  FIFO occupancy
state  out  2  0 IDLE, 1 FILL, 2 RUN
underflow  out  1  sticky
overflow  out  1  sticky
clr_err  in  1  clears sticky flags

Behaviour:
- Reset: phase=0, state=IDLE, level=0, hold register=IDLE_WORD, out_data = IDLE_WORD[4:0] on every channel, clk_pattern=5'b11111, flags=0.
- phase toggles every cycle, including in IDLE.
- Edge with phase==0: out_data <= hold[9:5] per channel; clk_pattern <= 5'b00000.
- Edge with phase==1: the "pop edge". clk_pattern <= 5'b11111. A word is selected into hold:
  - IDLE: IDLE_WORD.
  - FILL: if level >= START_LEVEL, pop the FIFO head and go to RUN. Otherwise select IDLE_WORD.
  - RUN: if non-empty, pop the head. If empty, select IDLE_WORD, set underflow and go to FILL.
  - out_data <= selected[4:0].
- Push: on in_valid && in_ready. The word is visible to a pop one edge later.
- Minimum latency from push to low half on out_data: 2 edges, when in RUN and the word is at the FIFO head.
- in_valid with enable=1 and level==DEPTH: word dropped, overflow set.
- in_valid with enable=0: ignored; no flag.
- Simultaneous push and pop: level unchanged. Empty is evaluated on pre-edge level, so a push into an empty FIFO on the pop edge still causes underflow.
- enable falling: next edge forces state=IDLE and level=0, pointers flushed. The half-word currently in hold completes, then IDLE_WORD halves follow.
- enable rising: IDLE->FILL on the next edge.
- clr_err clears both flags. A new error in the same cycle wins (flag stays 1).
- Pointers wrap modulo DEPTH. level saturates at DEPTH by construction.
- Async reset mid-word: immediate return to reset values.

Optional Feature:
TMDS_PRBS_EN
- Defined: adds input port prbs_en (1 bit). Each channel has a PRBS7 generator (x^7+x^6+1), seeded 7'h7F at reset.
- When prbs_en=1, out_data of each channel carries the next 5 PRBS bits each cycle, LSB = oldest bit. FIFO pops, state and flags behave unchanged.
- Not defined: no port, no PRBS logic; out_data always follows hold.

Test Plan:
- Reset, enable=0 for 10 cycles -> out_data alternates IDLE_WORD[4:0]/[9:5] on all channels; clk_pattern alternates 11111/00000, 11111 when phase=0; state=0.
- enable=1, push 4 words 10'h155,10'h2AA,10'h0F0,10'h30F (ch0) at one per 2 cycles -> state goes 1 then 2 at the first pop edge with level>=4; out_data ch0 = 5'h15,5'h0A, then 5'h0A,5'h15 in order.
- Stop pushing in RUN -> after the FIFO drains, underflow=1 and state=1; out_data returns to IDLE_WORD halves; clr_err=1 -> underflow=0.
- Push 9 words with no pops, enable=1, START_LEVEL=DEPTH+... held in FILL via DEPTH=8 -> level=8, in_ready=0, overflow=1 on 9th push, level stays 8.
- Deassert enable with level=5 -> next edge state=0, level=0, in_ready=0; no flags set.
- TMDS_PRBS_EN with prbs_en=1 -> out_data ch0 matches reference PRBS7 sequence from seed 7'h7F for 200 cycles; FIFO still drains at 1 word/2 cycles.
